// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - fetch/data arbiter onto one single-ported variable-latency memory
//
// Purpose: grants the RV32I fetch stage or memory stage access to a shared
// req/ack memory, returns completion pulses and read data, and drives the
// per-stage stall signals for the hazard unit. Accesses that never get an ack
// are ended by a timeout with bus_err. Killed fetches drain silently.
//
// Optional feature macro: MEM_ARB_RR_EN
//   defined   -> round-robin between fetch and data when both are pending
//   undefined -> data always wins over fetch
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   if_req/if_addr/if_kill    fetch request, address, branch-redirect kill
//   if_rdata/if_valid         fetched word and its one-cycle completion pulse
//   if_stall                  fetch stage hold
//   d_req/d_we/d_addr/d_wdata/d_be  data request fields
//   d_rdata/d_valid           load data and its one-cycle completion pulse
//   d_stall                   memory stage hold
//   bus_err                   pulses with the valid of a timed-out access
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  registered memory request
//   mem_ack/mem_rdata         memory completion and read data

module core_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_stall,
  output logic                bus_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DRAIN_I} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;   // 0 = fetch, 1 = data
  logic [CNT_W-1:0] tcnt;

  logic d_elig;
  logic i_elig;
  logic grant_d;
  logic grant_i;
  logic timeout;

  // A requester whose valid is high this cycle is the one just served and
  // must not be regranted on the same (stale) request.
  assign d_elig = d_req & ~d_valid;
  assign i_elig = if_req & ~if_kill & ~if_valid;

`ifdef MEM_ARB_RR_EN
  assign grant_d = (state == IDLE) & d_elig & (~i_elig | ~last_grant);
`else
  assign grant_d = (state == IDLE) & d_elig;
`endif
  assign grant_i = (state == IDLE) & i_elig & ~grant_d;

  // tcnt holds (busy cycles - 1); an ack on the final allowed cycle wins.
  assign timeout = (TIMEOUT != 0) && (tcnt == CNT_W'(TO_LAST)) && !mem_ack;

  assign if_stall = rst & if_req & ~if_valid & ~if_kill;
  assign d_stall  = rst & d_req & ~d_valid;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      BUSY_D: begin
        if (mem_ack || timeout) state_nxt = IDLE;
      end
      BUSY_I: begin
        if (mem_ack || timeout) state_nxt = IDLE;
        else if (if_kill)       state_nxt = DRAIN_I;
      end
      DRAIN_I: begin
        if (mem_ack || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output/control decode
  logic load_mem;
  logic end_tx;
  logic i_done;
  logic d_done;
  logic err_done;

  always_comb begin
    load_mem = 1'b0;
    end_tx   = 1'b0;
    i_done   = 1'b0;
    d_done   = 1'b0;
    err_done = 1'b0;
    case (state)
      IDLE: begin
        load_mem = grant_d | grant_i;
      end
      BUSY_D: begin
        end_tx   = mem_ack | timeout;
        d_done   = mem_ack | timeout;
        err_done = timeout;
      end
      BUSY_I: begin
        // A kill coinciding with ack or timeout discards the result.
        end_tx   = mem_ack | timeout;
        i_done   = (mem_ack | timeout) & ~if_kill;
        err_done = timeout & ~if_kill;
      end
      DRAIN_I: begin
        end_tx   = mem_ack | timeout;
      end
      default: ;
    endcase
  end

  // Registered memory request, completion pulses and read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      bus_err    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      last_grant <= 1'b0;
      tcnt       <= '0;
    end else begin
      if_valid <= i_done;
      d_valid  <= d_done;
      bus_err  <= err_done;

      if (load_mem) begin
        mem_req    <= 1'b1;
        mem_we     <= grant_d & d_we;
        mem_addr   <= grant_d ? d_addr : if_addr;
        mem_wdata  <= grant_d ? d_wdata : '0;
        mem_be     <= grant_d ? d_be : '1;
        last_grant <= grant_d;
        tcnt       <= '0;
      end else if (end_tx) begin
        mem_req <= 1'b0;
        tcnt    <= '0;
      end else if (state != IDLE) begin
        tcnt <= tcnt + CNT_W'(1);
      end

      if (i_done) if_rdata <= err_done ? '0 : mem_rdata;
      if (d_done) d_rdata  <= err_done ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - scoreboard bench for core_mem_arbiter

module tb_core_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_kill = 1'b0;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          if_stall;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          d_stall;
  logic          bus_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  core_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];

  // Monitor: pops expectations whenever a completion pulse is presented.
  logic [31:0] if_model = '0;
  logic [31:0] d_model = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if_model = '0;
        d_model  = '0;
      end else begin
        if (if_valid) begin
          if (iq.size() == 0) check("if_valid_unexpected", 32'(if_valid), 32'd0);
          else begin
            e = iq.pop_front();
            check("if_rdata", if_rdata, e.rdata);
            check("if_bus_err", 32'(bus_err), 32'(e.err));
            if_model = e.rdata;
          end
        end else check("if_rdata_hold", if_rdata, if_model);
        if (d_valid) begin
          if (dq.size() == 0) check("d_valid_unexpected", 32'(d_valid), 32'd0);
          else begin
            e = dq.pop_front();
            check("d_rdata", d_rdata, e.rdata);
            check("d_bus_err", 32'(bus_err), 32'(e.err));
            d_model = e.rdata;
          end
        end else check("d_rdata_hold", d_rdata, d_model);
        if (!if_valid && !d_valid) check("bus_err_alone", 32'(bus_err), 32'd0);
        check("if_stall", 32'(if_stall), 32'(if_req & ~if_valid & ~if_kill));
        check("d_stall", 32'(d_stall), 32'(d_req & ~d_valid));
      end
    end
  end

  // Stimulus-side state
  bit          killed [logic [31:0]];
  bit          f_have = 0;
  bit          d_have = 0;
  int          f_n = 0;
  int          d_n = 0;
  int          phase = 0;
  int          k = 0;
  int          lat = 0;
  bit          owner = 0;          // 0 fetch, 1 data
  bit          last_kind = 0;      // 0 fetch, 1 data
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [5:0]  cap_ctl;
  bit          prev_d_elig = 0;
  bit          prev_i_elig = 0;
  logic [31:0] prev_i_addr = '0;
  logic [31:0] prev_d_addr = '0;
  logic [31:0] prev_d_wdata = '0;
  logic        prev_d_we = 1'b0;
  logic [3:0]  prev_d_be = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_drv(input bit allow);
    if_kill = 1'b0;
    if (f_have && if_valid) begin
      f_have = 0;
      if_req = 1'b0;
    end else if (f_have && $urandom_range(0, 11) == 0) begin
      killed[if_addr] = 1;
      if_kill = 1'b1;
      f_n++;
      if_addr = 32'h1000_0000 + 32'(f_n * 4);
    end else if (!f_have && allow && $urandom_range(0, 3) != 0) begin
      f_n++;
      if_addr = 32'h1000_0000 + 32'(f_n * 4);
      if_req = 1'b1;
      f_have = 1;
    end
  endtask

  task automatic data_drv(input bit allow);
    if (d_have && d_valid) begin
      d_have = 0;
      d_req = 1'b0;
    end else if (!d_have && allow && $urandom_range(0, 2) != 0) begin
      d_n++;
      d_addr  = 32'h2000_0000 + 32'(d_n * 4);
      d_we    = 1'($urandom);
      d_be    = 4'($urandom);
      d_wdata = $urandom;
      d_req   = 1'b1;
      d_have  = 1;
    end
  endtask

  task automatic push_result(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    if (owner) dq.push_back(e);
    else if (!killed.exists(cap_addr)) iq.push_back(e);
  endtask

  // Memory model: random latency, ack or let the access time out.
  task automatic resp_step();
    mem_ack = 1'b0;
    if (phase == 2) begin
      check("mem_req_drop", 32'(mem_req), 32'd0);
      phase = 0;
    end else if (phase == 0) begin
      if (mem_req) begin
        owner = (mem_addr[31:28] == 4'h2);
        if (owner) begin
          check("grant_d_elig", 32'(prev_d_elig), 32'd1);
          check("grant_d_addr", mem_addr, prev_d_addr);
          check("grant_d_wdata", mem_wdata, prev_d_wdata);
          check("grant_d_ctl", {mem_we, mem_be}, {prev_d_we, prev_d_be});
`ifdef MEM_ARB_RR_EN
          if (prev_i_elig) check("rr_data_turn", 32'(last_kind), 32'd0);
`endif
          last_kind = 1;
        end else begin
          check("grant_i_elig", 32'(prev_i_elig), 32'd1);
          check("grant_i_addr", mem_addr, prev_i_addr);
          check("grant_i_ctl", {mem_we, mem_be}, 5'b0_1111);
`ifdef MEM_ARB_RR_EN
          if (prev_d_elig) check("rr_fetch_turn", 32'(last_kind), 32'd1);
`else
          check("data_priority", 32'(prev_d_elig), 32'd0);
`endif
          last_kind = 0;
        end
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        cap_ctl   = {mem_req, mem_we, mem_be};
        k   = 1;
        lat = $urandom_range(0, TO + 1);
        phase = 1;
      end
    end else begin
      k++;
      check("mem_addr_stable", mem_addr, cap_addr);
      check("mem_wdata_stable", mem_wdata, cap_wdata);
      check("mem_ctl_stable", {mem_req, mem_we, mem_be}, cap_ctl);
    end
    if (phase == 1) begin
      if (k == lat + 1) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        push_result(mem_rdata, 1'b0);
        phase = 2;
      end else if (k == TO) begin
        push_result(32'd0, 1'b1);
        phase = 2;
      end
    end
  endtask

  task automatic record_prev();
    prev_d_elig  = d_req & ~d_valid;
    prev_i_elig  = if_req & ~if_kill & ~if_valid;
    prev_i_addr  = if_addr;
    prev_d_addr  = d_addr;
    prev_d_wdata = d_wdata;
    prev_d_we    = d_we;
    prev_d_be    = d_be;
  endtask

  initial begin
    int cnt;
    bit done;

    // Reset state, with requests asserted to show stalls are held low too
    if_req = 1'b1;
    d_req  = 1'b1;
    repeat (2) tick();
    check("rst_mem", {mem_req, mem_we, mem_be, mem_addr[3:0]}, 10'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_valids", {if_valid, d_valid, bus_err, if_stall, d_stall}, 5'd0);
    check("rst_rdata", if_rdata | d_rdata, 32'd0);
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    rst = 1'b1;

    // Lone fetch, L=2
    tick();
    if_req  = 1'b1;
    if_addr = 32'h10;
    iq.push_back('{rdata: 32'h0050_0093, err: 1'b0});
    tick();
    check("lone_c1_req", 32'(mem_req), 32'd1);
    check("lone_c1_addr", mem_addr, 32'h10);
    check("lone_c1_ctl", {mem_we, mem_be}, 5'b0_1111);
    tick();
    check("lone_c2_req", 32'(mem_req), 32'd1);
    check("lone_c2_stall", 32'(if_stall), 32'd1);
    tick();
    check("lone_c3_req", 32'(mem_req), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0050_0093;
    tick();
    mem_ack = 1'b0;
    check("lone_c4_valid", 32'(if_valid), 32'd1);
    check("lone_c4_req", 32'(mem_req), 32'd0);
    check("lone_c4_stall", 32'(if_stall), 32'd0);
    if_req = 1'b0;
    last_kind = 0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      fetch_drv(1);
      data_drv(1);
      resp_step();
      record_prev();
    end
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      tick();
      fetch_drv(0);
      data_drv(0);
      resp_step();
      record_prev();
      done = !f_have && !d_have && phase == 0 && iq.size() == 0 && dq.size() == 0;
    end
    check("drain_complete", 32'(done), 32'd1);
    if_kill = 1'b0;
    if_req  = 1'b0;
    d_req   = 1'b0;
    repeat (3) tick();

    // Load that is never acked times out after TO busy cycles
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h100;
    d_be    = 4'hF;
    dq.push_back('{rdata: 32'd0, err: 1'b1});
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (mem_req) cnt++;
      else if (cnt > 0) break;
    end
    check("timeout_cycles", 32'(cnt), 32'(TO));
    check("timeout_pulse", {d_valid, bus_err, mem_req}, 3'b110);
    check("timeout_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    tick();

    // Store fields held while busy, then reset in the middle of BUSY_D
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h104;
    d_be    = 4'b0011;
    d_wdata = 32'hDEAD_BEEF;
    tick();
    tick();
    check("store_ctl", {mem_req, mem_we, mem_be}, 6'b11_0011);
    check("store_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    check("store_hold", {mem_req, mem_we, mem_be}, 6'b11_0011);
    rst = 1'b0;
    #1;
    check("midrst_mem", {mem_req, mem_we, mem_be}, 6'd0);
    check("midrst_addr", mem_addr | mem_wdata, 32'd0);
    check("midrst_out", {if_valid, d_valid, bus_err, if_stall, d_stall}, 5'd0);
    d_req = 1'b0;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    check("post_rst_idle", 32'(mem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
